// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle MIPS control unit.
// Holds the opcode/funct encodings, the FSM state encoding and the
// datapath select codes driven onto WDSel/NPCOp/EXTOp/ALUOp/GPRSel.
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // GPR write-data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // Next-PC select
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    // ALU operation (2-bit core code; wider ALUOp ports zero-extend it)
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    // Destination register select
    localparam logic [1:0] GPR_RD   = 2'b00;
    localparam logic [1:0] GPR_RT   = 2'b01;
    localparam logic [1:0] GPR_31   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BR     = 3'd5
    } state_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction-class decode of OP/Funct.
// Shared between the single-cycle and multicycle control units.
// Ports:
//   OP, Funct         in  opcode and function fields from the IR
//   is_addu..is_jal   out one-hot instruction class (all 0 if unsupported)
//   illegal           out 1 when OP/Funct is not a supported instruction
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    output logic       is_addu,
    output logic       is_subu,
    output logic       is_ori,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_jal,
    output logic       illegal
);

    logic is_rtype;

    assign is_rtype = (OP == OP_RTYPE);
    assign is_addu  = is_rtype && (Funct == FN_ADDU);
    assign is_subu  = is_rtype && (Funct == FN_SUBU);
    assign is_ori   = (OP == OP_ORI);
    assign is_lw    = (OP == OP_LW);
    assign is_sw    = (OP == OP_SW);
    assign is_beq   = (OP == OP_BEQ);
    assign is_jal   = (OP == OP_JAL);

    // An R-type opcode with an unknown funct is also illegal.
    assign illegal  = !(is_addu || is_subu || is_ori || is_lw ||
                        is_sw || is_beq || is_jal);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/BR).
// Drives the shared datapath selects per state, stalls FETCH/MEM on
// mem_rdy, flags illegal instructions and counts retired instructions.
// Ports:
//   clk, rst (async, active-low)
//   OP, Funct, Zero, mem_rdy                          inputs
//   BSel, WDSel, RFWr, DMWr, NPCOp, EXTOp, ALUOp,
//   PCWr, IRWr, GPRSel                                datapath controls
//   illegal, retire                                   one-cycle pulses
//   instret                                           retired count (wraps)
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OP,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_rdy,
    output logic               BSel,
    output logic [1:0]         WDSel,
    output logic               RFWr,
    output logic               DMWr,
    output logic [1:0]         NPCOp,
    output logic [1:0]         EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCWr,
    output logic               IRWr,
    output logic [1:0]         GPRSel,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   instret
);

    state_t state, state_nx;

    logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_jal, dec_ill;
    logic mem_ok;

    logic       bsel_c, rfwr_c, dmwr_c, pcwr_c, irwr_c, ill_c, retire_c;
    logic [1:0] wdsel_c, npcop_c, extop_c, aluop_c, gprsel_c;

    mc_ctrl_dec u_dec (
        .OP      (OP),
        .Funct   (Funct),
        .is_addu (is_addu),
        .is_subu (is_subu),
        .is_ori  (is_ori),
        .is_lw   (is_lw),
        .is_sw   (is_sw),
        .is_beq  (is_beq),
        .is_jal  (is_jal),
        .illegal (dec_ill)
    );

    assign mem_ok = MEM_WAIT ? mem_rdy : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (retire_c) begin
            instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        bsel_c   = 1'b0;
        rfwr_c   = 1'b0;
        dmwr_c   = 1'b0;
        pcwr_c   = 1'b0;
        irwr_c   = 1'b0;
        ill_c    = 1'b0;
        retire_c = 1'b0;
        wdsel_c  = WD_ALU;
        npcop_c  = NPC_PC4;
        extop_c  = EXT_ZERO;
        aluop_c  = ALU_ADD;
        gprsel_c = GPR_RD;

        case (state)
            ST_FETCH: begin
                irwr_c = mem_ok;
                pcwr_c = mem_ok;
                if (mem_ok) state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_ill) begin
                    ill_c    = 1'b1;
                    state_nx = ST_FETCH;
                end else if (is_jal) begin
                    state_nx = ST_WB;
                end else if (is_beq) begin
                    state_nx = ST_BR;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                aluop_c  = is_subu ? ALU_SUB : (is_ori ? ALU_OR : ALU_ADD);
                bsel_c   = is_ori || is_lw || is_sw;
                extop_c  = (is_lw || is_sw) ? EXT_SIGN : EXT_ZERO;
                state_nx = (is_lw || is_sw) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmwr_c = is_sw && mem_ok;
                if (mem_ok) begin
                    // Stores complete here; loads still need write-back.
                    retire_c = is_sw;
                    state_nx = is_sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rfwr_c   = 1'b1;
                retire_c = 1'b1;
                state_nx = ST_FETCH;
                if (is_jal) begin
                    gprsel_c = GPR_31;
                    wdsel_c  = WD_PC4;
                    pcwr_c   = 1'b1;
                    npcop_c  = NPC_JMP;
                end else if (is_lw) begin
                    gprsel_c = GPR_RT;
                    wdsel_c  = WD_DM;
                end else if (is_ori) begin
                    gprsel_c = GPR_RT;
                end else if (is_addu || is_subu) begin
                    gprsel_c = GPR_RD;
                end
            end
            ST_BR: begin
                aluop_c  = ALU_SUB;
                extop_c  = EXT_SIGN;
                npcop_c  = NPC_BR;
                pcwr_c   = Zero;
                retire_c = 1'b1;
                state_nx = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    // The state register alone would leave FETCH driving IRWr/PCWr during
    // reset, so every output is forced low while rst is asserted.
    assign BSel    = rst & bsel_c;
    assign RFWr    = rst & rfwr_c;
    assign DMWr    = rst & dmwr_c;
    assign PCWr    = rst & pcwr_c;
    assign IRWr    = rst & irwr_c;
    assign illegal = rst & ill_c;
    assign retire  = rst & retire_c;
    assign WDSel   = rst ? wdsel_c  : 2'b00;
    assign NPCOp   = rst ? npcop_c  : 2'b00;
    assign EXTOp   = rst ? extop_c  : 2'b00;
    assign GPRSel  = rst ? gprsel_c : 2'b00;
    assign ALUOp   = rst ? ALUOP_W'(aluop_c) : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. A driver walks each instruction
// through its cycles, pushing the expected per-cycle outputs; a monitor pops
// and compares on the falling edge. CNT_W=4 so instret wrap is exercised.
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       bsel;
        logic [1:0] wdsel;
        logic       rfwr;
        logic       dmwr;
        logic [1:0] npcop;
        logic [1:0] extop;
        logic [1:0] aluop;
        logic       pcwr;
        logic       irwr;
        logic [1:0] gprsel;
        logic       illegal;
        logic       retire;
        logic [3:0] instret;
    } out_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       OP = 6'd0;
    logic [5:0]       Funct = 6'd0;
    logic             Zero = 1'b0;
    logic             mem_rdy = 1'b1;
    logic             BSel, RFWr, DMWr, PCWr, IRWr, illegal, retire;
    logic [1:0]       WDSel, NPCOp, EXTOp, ALUOp, GPRSel;
    logic [CNT_W-1:0] instret;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   retired = 0;   // reference retired-instruction count
    int   cyc = 0;

    mc_ctrl #(.ALUOP_W(2), .CNT_W(CNT_W), .MEM_WAIT(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .OP      (OP),
        .Funct   (Funct),
        .Zero    (Zero),
        .mem_rdy (mem_rdy),
        .BSel    (BSel),
        .WDSel   (WDSel),
        .RFWr    (RFWr),
        .DMWr    (DMWr),
        .NPCOp   (NPCOp),
        .EXTOp   (EXTOp),
        .ALUOp   (ALUOp),
        .PCWr    (PCWr),
        .IRWr    (IRWr),
        .GPRSel  (GPRSel),
        .illegal (illegal),
        .retire  (retire),
        .instret (instret)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Idle outputs carrying the reference instret value.
    function automatic out_t base();
        out_t e;
        e = '0;
        e.instret = 4'(retired % 16);
        return e;
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic zr, input logic mr, input out_t e);
        @(posedge clk);
        #1;
        rst = r; OP = op; Funct = fn; Zero = zr; mem_rdy = mr;
        exp_q.push_back(e);
    endtask

    task automatic do_retire();
        retired = retired + 1;
    endtask

    // One instruction: fw FETCH stalls, mw MEM stalls; abort drops rst
    // after the MEM stalls instead of completing.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic zr,
                             input bit abort);
        out_t e;
        bit addu, subu, ori, lw, sw, beq, jal, legal;
        addu  = (op == 6'h00) && (fn == 6'h21);
        subu  = (op == 6'h00) && (fn == 6'h23);
        ori   = (op == 6'h0d);
        lw    = (op == 6'h23);
        sw    = (op == 6'h2b);
        beq   = (op == 6'h04);
        jal   = (op == 6'h03);
        legal = addu || subu || ori || lw || sw || beq || jal;

        for (int i = 0; i < fw; i++) step(1'b1, op, fn, rb(), 1'b0, base());
        e = base(); e.irwr = 1'b1; e.pcwr = 1'b1;
        step(1'b1, op, fn, rb(), 1'b1, e);

        e = base(); e.illegal = !legal;
        step(1'b1, op, fn, rb(), rb(), e);
        if (!legal) return;

        if (jal) begin
            e = base(); e.rfwr = 1'b1; e.gprsel = 2'b10; e.wdsel = 2'b10;
            e.pcwr = 1'b1; e.npcop = 2'b10; e.retire = 1'b1;
            step(1'b1, op, fn, rb(), rb(), e);
            do_retire();
            return;
        end
        if (beq) begin
            e = base(); e.aluop = 2'b01; e.extop = 2'b01; e.npcop = 2'b01;
            e.pcwr = zr; e.retire = 1'b1;
            step(1'b1, op, fn, zr, rb(), e);
            do_retire();
            return;
        end

        e = base();
        e.aluop = subu ? 2'b01 : (ori ? 2'b10 : 2'b00);
        e.bsel  = ori || lw || sw;
        e.extop = (lw || sw) ? 2'b01 : 2'b00;
        step(1'b1, op, fn, rb(), rb(), e);

        if (lw || sw) begin
            for (int i = 0; i < mw; i++) step(1'b1, op, fn, rb(), 1'b0, base());
            if (abort) begin
                retired = 0;
                step(1'b0, op, fn, rb(), 1'b1, base());
                step(1'b0, op, fn, rb(), 1'b1, base());
                return;
            end
            e = base();
            if (sw) begin e.dmwr = 1'b1; e.retire = 1'b1; end
            step(1'b1, op, fn, rb(), 1'b1, e);
            if (sw) begin do_retire(); return; end
        end

        e = base(); e.rfwr = 1'b1; e.retire = 1'b1;
        e.gprsel = (lw || ori) ? 2'b01 : 2'b00;
        e.wdsel  = lw ? 2'b01 : 2'b00;
        step(1'b1, op, fn, rb(), rb(), e);
        do_retire();
    endtask

    // Monitor: every falling edge with a pending expectation is a check.
    always @(negedge clk) begin
        out_t e, a;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {BSel, WDSel, RFWr, DMWr, NPCOp, EXTOp, ALUOp, PCWr, IRWr,
                 GPRSel, illegal, retire, instret};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL outputs cycle %0d got=%h exp=%h", cyc, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [5:0] op, fn;

        // Reset held with mem_rdy=1: everything quiet, instret 0.
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 6'd0, rb(), 1'b1, base());

        // Directed: ADDU, LW with 2 MEM stalls, BEQ taken/not, JAL, illegal.
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 0, 2, 1'b0, 1'b0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h3f, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h00, 6'h22, 1, 0, 1'b0, 1'b0);
        // SW stalled in MEM with reset dropped mid-stall.
        run_instr(6'h2b, 6'h00, 0, 2, 1'b0, 1'b1);

        // Random mix; well over 16 retires so the 4-bit counter wraps.
        for (int n = 0; n < 70; n++) begin
            k  = $urandom_range(0, 8);
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: begin op = 6'h00; fn = 6'h21; end
                1: begin op = 6'h00; fn = 6'h23; end
                2: op = 6'h0d;
                3: op = 6'h23;
                4: op = 6'h2b;
                5: op = 6'h04;
                6: op = 6'h03;
                7: op = ($urandom_range(0, 1) != 0) ? 6'h3f : 6'h08;
                default: begin op = 6'h00; fn = 6'h20; end
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      rb(), 1'b0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
